programmable_clock_divider: RTL and testbench
=============================================

// Module: programmable_clock_divider
// PURPOSE
//  Successor to the fixed 4-way system prescaler. Divides clk by any runtime
//  divisor 1..2^DIV_W-1, produces a 1-cycle tick (clock enable) and a
//  flop-driven clk_div square wave. Divisor changes take effect only on a
//  period boundary, so no truncated or glitched period is ever emitted.
//  Sits between the config register block and timer/flasher logic.
// PARAMETERS
//  DIV_W      16  width of divisor and counter
//  RESET_DIV  64  divisor active after reset (1 <= RESET_DIV < 2^DIV_W)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  enable     in   1      1 = run; 0 = hold idle
//  cfg_valid  in   1      divisor update request
//  cfg_div    in   DIV_W  requested divisor N; 0 is treated as 1
//  cfg_ready  out  1      update accepted when cfg_valid && cfg_ready
//  tick       out  1      one-cycle pulse on the last cycle of each period
//  clk_div    out  1      divided clock, registered output
//  active_div out  DIV_W  divisor currently in use (after 0->1 mapping)
// BEHAVIOUR
//  Reset: cnt=0, active_div=RESET_DIV, pend_vld=0, tick=0, clk_div=0, cfg_ready=1.
//  Reset mid-period aborts the period immediately; no tick is issued.
//  States (from enable, pend_vld): IDLE (enable=0), RUN, SWITCH_PENDING.
//  Counter: in RUN, cnt counts 0..N-1 and wraps to 0. N = active_div.
//  tick: 1 in exactly the cycles where state != IDLE and cnt == N-1.
//    N=1 -> tick every enabled cycle.
//  clk_div: a flop. In any cycle it equals (state != IDLE && N >= 2 && cnt >= N>>1).
//    High for ceil(N/2) cycles and low for floor(N/2) cycles; a period starts low.
//    N=1 -> clk_div stays 0. clk is never forwarded combinationally.
//  Config handshake:
//    cfg_ready = !pend_vld. On accept, cfg_div is staged in pend_div and pend_vld=1.
//    In IDLE: the staged value is applied on the next cycle. active_div is
//      updated and pend_vld cleared, so cfg_ready returns 1 one cycle after accept.
//    In RUN/SWITCH_PENDING: the staged value is applied in the cycle where
//      tick=1. cnt goes to 0 and the next period uses the new N. pend_vld
//      clears in that same edge.
//    A new request is never accepted while pend_vld=1; a later write does not
//      overwrite a pending one.
//    Accept in the same cycle as tick: that tick closes the old period. The new
//      value applies at the end of the following (old-N) period.
//  enable 1->0: next edge forces cnt=0, tick=0, clk_div=0. Partial period is discarded.
//  enable 0->1: cnt starts at 0 on the first enabled cycle. First tick comes N
//    cycles later, counting the first enabled cycle as cycle 1.
//  Arithmetic: cnt and the compare are DIV_W bits unsigned; N-1 never underflows
//    because N >= 1. Max N = 2^DIV_W-1.
//  Latency: tick/clk_div reflect cnt of the same cycle (registered, no extra lag).
// TESTING
//  1. Reset, enable=1, default N=64 -> tick every 64 cycles; clk_div low 32 / high 32.
//  2. Write N=5 while idle, then enable -> tick at cycles 5,10,15;
//     clk_div pattern 0,0,1,1,1 per period.
//  3. Running N=8, write N=3 at cnt=2 -> cfg_ready=0 until the tick at cnt=7;
//     next periods are 3 cycles long; no period shorter than 8 before the switch.
//  4. N=1 and N=0 writes -> active_div=1, tick held 1 while enabled, clk_div=0.
//  5. Drop enable at cnt=4 of N=10, re-enable -> no tick during idle;
//     first tick 10 cycles after re-enable.
//  6. Assert rst at cnt=30 of N=64 with a pending write of N=7 -> outputs at reset
//     values, pending write discarded, active_div=64.

Source files
------------

// File: rtl/programmable_clock_divider.sv
// rtl/programmable_clock_divider.sv - runtime-programmable clock divider with tick and registered divided clock
module programmable_clock_divider #(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             clk_div,
  output logic [DIV_W-1:0] active_div
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    RUN            = 2'd1,
    SWITCH_PENDING = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0] RESET_N = DIV_W'(RESET_DIV);

  state_t           state_q, state_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic [DIV_W-1:0] active_n;
  logic [DIV_W-1:0] pend_div_q, pend_div_n;
  logic             pend_vld_q, pend_vld_n;
  logic             tick_n, clk_div_n;
  logic             running, wrap, accept;
  logic [DIV_W-1:0] last_n, half_n;

  assign cfg_ready = !pend_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_div <= RESET_N;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      tick       <= 1'b0;
      clk_div    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      active_div <= active_n;
      pend_div_q <= pend_div_n;
      pend_vld_q <= pend_vld_n;
      tick       <= tick_n;
      clk_div    <= clk_div_n;
    end
  end

  // tick and clk_div are computed from the next cnt/divisor so the flops
  // line up with the counter value of the cycle they are visible in.
  always_comb begin
    running    = (state_q != IDLE);
    wrap       = running && (cnt_q == active_div - ONE);
    accept     = cfg_valid && !pend_vld_q;
    active_n   = active_div;
    pend_div_n = pend_div_q;
    pend_vld_n = pend_vld_q;
    cnt_n      = '0;

    if (pend_vld_q && (!running || wrap)) begin
      active_n   = pend_div_q;
      pend_vld_n = 1'b0;
    end

    if (accept) begin
      pend_vld_n = 1'b1;
      pend_div_n = (cfg_div == '0) ? ONE : cfg_div;
    end

    if (enable && running && !wrap) begin
      cnt_n = cnt_q + ONE;
    end

    if (!enable) begin
      state_n = IDLE;
    end else if (pend_vld_n) begin
      state_n = SWITCH_PENDING;
    end else begin
      state_n = RUN;
    end

    last_n    = active_n - ONE;
    half_n    = active_n >> 1;
    tick_n    = enable && (cnt_n == last_n);
    clk_div_n = enable && (active_n >= TWO) && (cnt_n >= half_n);
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb/tb_programmable_clock_divider.sv - self-checking bench for programmable_clock_divider
module tb_programmable_clock_divider;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        tick;
  logic        clk_div;
  logic [15:0] active_div;

  programmable_clock_divider #(.DIV_W(16), .RESET_DIV(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .tick       (tick),
    .clk_div    (clk_div),
    .active_div (active_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        clk_div;
    logic        cfg_ready;
    logic [15:0] active_div;
  } exp_t;

  typedef struct {
    int div_in;
    bit do_write;
    int exp_n;
    int cycles;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_tick(input int n, input int k);
    return (k % n) == 0;
  endfunction

  function automatic bit f_clk(input int n, input int k);
    return (n >= 2) && (((k - 1) % n) >= (n / 2));
  endfunction

  task automatic expect_cycle(input bit t, input bit c, input bit r, input int a);
    exp_t e;
    sb.push_back('{t, c, r, 16'(a)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("tick", {31'd0, tick}, {31'd0, e.tick});
      chk("clk_div", {31'd0, clk_div}, {31'd0, e.clk_div});
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, e.cfg_ready});
      chk("active_div", {16'd0, active_div}, {16'd0, e.active_div});
    end
  endtask

  task automatic run_period(input int n, input int k0, input int len, input int act);
    for (int k = k0; k < k0 + len; k++) begin
      expect_cycle(f_tick(n, k), f_clk(n, k), 1'b1, act);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    @(posedge clk);
    #1;
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_clk_div", {31'd0, clk_div}, 0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst_active_div", {16'd0, active_div}, 64);
    rst = 1'b0;
    expect_cycle(1'b0, 1'b0, 1'b1, 64);
  endtask

  task automatic idle_write(input int d, input int exp_n, input int old_n);
    cfg_valid = 1'b1;
    cfg_div   = 16'(d);
    expect_cycle(1'b0, 1'b0, 1'b0, old_n);
    cfg_valid = 1'b0;
    expect_cycle(1'b0, 1'b0, 1'b1, exp_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    vecs[0] = '{64, 1'b0, 64, 130};
    vecs[1] = '{5,  1'b1, 5,  15};
    vecs[2] = '{1,  1'b1, 1,  6};
    vecs[3] = '{0,  1'b1, 1,  6};
    vecs[4] = '{2,  1'b1, 2,  8};
    vecs[5] = '{3,  1'b1, 3,  9};
    vecs[6] = '{8,  1'b1, 8,  17};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      if (vecs[v].do_write) idle_write(vecs[v].div_in, vecs[v].exp_n, 64);
      enable = 1'b1;
      run_period(vecs[v].exp_n, 1, vecs[v].cycles, vecs[v].exp_n);
      enable = 1'b0;
      expect_cycle(1'b0, 1'b0, 1'b1, vecs[v].exp_n);
    end

    // Switch from N=8 to N=3 requested at cnt=2; a second write must not overwrite it.
    do_reset();
    idle_write(8, 8, 64);
    enable = 1'b1;
    run_period(8, 1, 3, 8);
    cfg_valid = 1'b1;
    cfg_div   = 16'd3;
    expect_cycle(f_tick(8, 4), f_clk(8, 4), 1'b0, 8);
    cfg_div = 16'd5;
    for (int k = 5; k <= 8; k++) begin
      expect_cycle(f_tick(8, k), f_clk(8, k), 1'b0, 8);
    end
    cfg_valid = 1'b0;
    run_period(3, 1, 9, 3);

    // Drop enable at cnt=4 of N=10, then re-enable.
    do_reset();
    idle_write(10, 10, 64);
    enable = 1'b1;
    run_period(10, 1, 5, 10);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle(1'b0, 1'b0, 1'b1, 10);
    enable = 1'b1;
    run_period(10, 1, 12, 10);

    // Reset at cnt=30 of N=64 with a pending write of N=7.
    do_reset();
    enable = 1'b1;
    run_period(64, 1, 31, 64);
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    expect_cycle(f_tick(64, 32), f_clk(64, 32), 1'b0, 64);
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tick", {31'd0, tick}, 0);
    chk("async_rst_clk_div", {31'd0, clk_div}, 0);
    chk("async_rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("async_rst_active_div", {16'd0, active_div}, 64);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_period(64, 1, 66, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
